// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - kernel/pixel sequencer and result counter for a KxK convolution engine
module conv_sequencer #(
  parameter int MAX_XRES = 128,
  parameter int MAX_YRES = 128,
  parameter int XRES1    = 16,
  parameter int XRES2    = 32,
  parameter int XRES3    = 64,
  parameter int XRES4    = 4,
  parameter int XRES5    = 8,
  parameter int K        = 3,
  parameter int WIDTH    = 16
) (
  input  logic                              clock,
  input  logic                              clock_areset_n,
  input  logic                              start,
  input  logic [2:0]                        xres_select,
  input  logic [$clog2(MAX_YRES+1)-1:0]     yres,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  input  logic                              kin_valid,
  output logic                              kin_ready,
  input  logic [WIDTH-1:0]                  kin_data,
  input  logic                              pin_valid,
  output logic                              pin_ready,
  input  logic [WIDTH-1:0]                  pin_data,
  output logic [2:0]                        cfg_xres_select,
  output logic                              kernel_data_shift,
  output logic [WIDTH-1:0]                  kernel_data,
  output logic                              data_shift,
  output logic [WIDTH-1:0]                  data,
  output logic                              enable_calc,
  input  logic                              result_valid
);

  localparam int XW = $clog2(MAX_XRES);
  localparam int YW = $clog2(MAX_YRES+1);
  localparam int RW = $clog2(MAX_XRES*MAX_YRES+1);
  localparam int KW = $clog2(K*K+1);

  localparam logic [XW-1:0] X_KM1  = XW'(K-1);
  localparam logic [YW-1:0] Y_KM1  = YW'(K-1);
  localparam logic [KW-1:0] K_LAST = KW'(K*K-1);

  typedef enum logic [2:0] {IDLE, LOAD_KERNEL, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_next;
  logic [XW:0]   xres_sel;
  logic          bad_cfg;
  logic          accept;
  logic [RW-1:0] exp_cols, exp_rows, exp_next;
  logic [XW-1:0] xres_last, x;
  logic [YW-1:0] yres_last, y;
  logic [KW-1:0] kcount;
  logic [RW-1:0] result_count, expected;
  logic          k_hs, p_hs, last_k, last_p;
  logic          rv_cnt, count_hit;

  // Decode the requested line length and validate the frame request
  always_comb begin
    xres_sel = '0;
    case (xres_select)
      3'd0:    xres_sel = (XW+1)'(XRES1);
      3'd1:    xres_sel = (XW+1)'(XRES2);
      3'd2:    xres_sel = (XW+1)'(XRES3);
      3'd3:    xres_sel = (XW+1)'(XRES4);
      3'd4:    xres_sel = (XW+1)'(XRES5);
      default: xres_sel = '0;
    endcase
    bad_cfg  = (xres_select > 3'd4) || (yres < YW'(K)) || (yres > YW'(MAX_YRES));
    exp_cols = RW'(xres_sel) - RW'(K-1);
    exp_rows = RW'(yres) - RW'(K-1);
    exp_next = exp_cols * exp_rows;
  end

  assign accept    = (state == IDLE) && start && !bad_cfg;
  assign k_hs      = kin_valid && (state == LOAD_KERNEL);
  assign p_hs      = pin_valid && (state == STREAM);
  assign last_k    = (kcount == K_LAST);
  assign last_p    = (x == xres_last) && (y == yres_last);
  assign rv_cnt    = result_valid && busy && (result_count != expected);
  assign count_hit = (result_count == expected) ||
                     (rv_cnt && ((result_count + RW'(1)) == expected));

  // State register
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) state <= IDLE;
    else                 state <= state_next;
  end

  // Next-state decode and state-derived stream controls
  always_comb begin
    state_next        = state;
    busy              = (state != IDLE);
    done              = (state == DONE);
    kin_ready         = (state == LOAD_KERNEL);
    pin_ready         = (state == STREAM);
    kernel_data_shift = k_hs;
    kernel_data       = (state == LOAD_KERNEL) ? kin_data : '0;
    data_shift        = p_hs;
    data              = (state == STREAM) ? pin_data : '0;
    case (state)
      IDLE:        if (accept) state_next = LOAD_KERNEL;
      LOAD_KERNEL: if (k_hs && last_k) state_next = STREAM;
      STREAM:      if (p_hs && last_p) state_next = DRAIN;
      DRAIN:       if (count_hit) state_next = DONE;
      DONE:        state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  // Configuration latch, raster counters, result counter and registered strobes
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      err             <= 1'b0;
      enable_calc     <= 1'b0;
      cfg_xres_select <= '0;
      xres_last       <= '0;
      yres_last       <= '0;
      expected        <= '0;
      kcount          <= '0;
      x               <= '0;
      y               <= '0;
      result_count    <= '0;
    end else begin
      err         <= (state == IDLE) && start && bad_cfg;
      enable_calc <= p_hs && (x >= X_KM1) && (y >= Y_KM1);
      if (accept) begin
        cfg_xres_select <= xres_select;
        xres_last       <= XW'(xres_sel - (XW+1)'(1));
        yres_last       <= yres - YW'(1);
        expected        <= exp_next;
        kcount          <= '0;
        x               <= '0;
        y               <= '0;
        result_count    <= '0;
      end else begin
        if (k_hs) kcount <= kcount + KW'(1);
        if (p_hs) begin
          if (x == xres_last) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
        if (rv_cnt) result_count <= result_count + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer
module tb_conv_sequencer;

  localparam int WIDTH = 16;

  logic              clock;
  logic              clock_areset_n;
  logic              start;
  logic [2:0]        xres_select;
  logic [7:0]        yres;
  logic              busy, done, err;
  logic              kin_valid, kin_ready;
  logic [WIDTH-1:0]  kin_data;
  logic              pin_valid, pin_ready;
  logic [WIDTH-1:0]  pin_data;
  logic [2:0]        cfg_xres_select;
  logic              kernel_data_shift;
  logic [WIDTH-1:0]  kernel_data;
  logic              data_shift;
  logic [WIDTH-1:0]  data;
  logic              enable_calc;
  logic              result_valid;

  conv_sequencer dut (
    .clock             (clock),
    .clock_areset_n    (clock_areset_n),
    .start             (start),
    .xres_select       (xres_select),
    .yres              (yres),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .kin_valid         (kin_valid),
    .kin_ready         (kin_ready),
    .kin_data          (kin_data),
    .pin_valid         (pin_valid),
    .pin_ready         (pin_ready),
    .pin_data          (pin_data),
    .cfg_xres_select   (cfg_xres_select),
    .kernel_data_shift (kernel_data_shift),
    .kernel_data       (kernel_data),
    .data_shift        (data_shift),
    .data              (data),
    .enable_calc       (enable_calc),
    .result_valid      (result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Engine stub: a result appears five cycles after each compute enable
  logic [4:0] pipe;
  always @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) pipe <= '0;
    else                 pipe <= {pipe[3:0], enable_calc};
  end
  assign result_valid = pipe[4];

  // Event monitor
  logic mon_clr;
  int   kshift_cnt, pix_cnt, res_seen, res_mark, done_cnt, err_cnt, viol;
  int   en_idx[$];
  int   done_res[$];
  always @(posedge clock) begin
    if (mon_clr) begin
      kshift_cnt <= 0; pix_cnt <= 0; res_seen <= 0; res_mark <= 0;
      done_cnt <= 0; err_cnt <= 0; viol <= 0;
      en_idx.delete();
      done_res.delete();
    end else begin
      if (kernel_data_shift) kshift_cnt <= kshift_cnt + 1;
      if (enable_calc) en_idx.push_back(pix_cnt - 1);
      if (data_shift) pix_cnt <= pix_cnt + 1;
      if (result_valid) res_seen <= res_seen + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_res.push_back(res_seen - res_mark);
        res_mark <= res_seen;
      end
      if (err) err_cnt <= err_cnt + 1;
      if ((kernel_data_shift && !kin_valid) || (data_shift && !pin_valid) ||
          (kernel_data_shift && kernel_data != kin_data) || (data_shift && data != pin_data))
        viol <= viol + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [46:0] v;
    v = {busy, done, err, enable_calc, kin_ready, pin_ready, kernel_data_shift,
         data_shift, cfg_xres_select, kernel_data, data};
    check(name, longint'(v), 0);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clock);
    mon_clr = 1'b0;
  endtask

  // One 4x4 frame (xres_select=3, yres=4); called at a negedge, returns in the busy-fall cycle
  task automatic run_frame(input bit gaps, input int abort_at, input bit mid_start);
    int sent, cyc;
    start = 1'b1; xres_select = 3'd3; yres = 8'd4;
    @(negedge clock);
    start = 1'b0; xres_select = 3'd0; yres = 8'd0;
    #1;
    check("busy_after_start", busy, 1);
    check("kin_ready_after_start", kin_ready, 1);
    sent = 0; cyc = 0;
    while (sent < 9 && cyc < 500) begin
      kin_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      kin_data  = WIDTH'(16'h0100 + sent);
      #1;
      if (kin_valid && kin_ready) sent++;
      @(negedge clock);
      cyc++;
    end
    kin_valid = 1'b0;
    check("kernel_words_sent", sent, 9);
    #1;
    check("pin_ready_no_bubble", pin_ready, 1);
    sent = 0;
    while (sent < 16 && cyc < 1000) begin
      pin_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pin_data  = WIDTH'(16'h0200 + sent);
      if (mid_start && sent == 5) begin
        start = 1'b1; xres_select = 3'd0; yres = 8'd10;
      end else begin
        start = 1'b0; xres_select = 3'd0; yres = 8'd0;
      end
      #1;
      if (pin_valid && pin_ready) sent++;
      @(negedge clock);
      cyc++;
      if (abort_at >= 0 && sent == abort_at) begin
        clock_areset_n = 1'b0;
        #1;
        check_all_zero("outputs_in_midframe_reset");
        pin_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    pin_valid = 1'b0;
    start = 1'b0;
    check("pixels_sent", sent, 16);
    cyc = 0;
    while (cyc < 100) begin
      #1;
      if (done) break;
      @(negedge clock);
      cyc++;
    end
    check("done_seen", done, 1);
    @(negedge clock);
    #1;
    check("busy_falls_after_done", busy, 0);
  endtask

  // Monitor totals for n back-to-back nominal frames
  task automatic frame_checks(input string tag, input int n);
    int base[4];
    base = '{10, 11, 14, 15};
    check({tag, "_kshift"}, kshift_cnt, 9 * n);
    check({tag, "_pixels"}, pix_cnt, 16 * n);
    check({tag, "_enables"}, en_idx.size(), 4 * n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < 4; i++)
        if (en_idx.size() > f * 4 + i)
          check({tag, "_enable_index"}, en_idx[f * 4 + i], base[i] + 16 * f);
    check({tag, "_done_pulses"}, done_cnt, n);
    for (int f = 0; f < n; f++)
      if (done_res.size() > f)
        check({tag, "_results_before_done"}, done_res[f], 4);
    check({tag, "_stream_violations"}, viol, 0);
    check({tag, "_err_pulses"}, err_cnt, 0);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [7:0] yr;
    bit         exp_err;
    bit         exp_busy;
    logic [2:0] exp_cfg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'd5, 8'd4,   1'b1, 1'b0, 3'd0};
    vecs[1] = '{3'd7, 8'd4,   1'b1, 1'b0, 3'd0};
    vecs[2] = '{3'd3, 8'd2,   1'b1, 1'b0, 3'd0};
    vecs[3] = '{3'd0, 8'd0,   1'b1, 1'b0, 3'd0};
    vecs[4] = '{3'd1, 8'd129, 1'b1, 1'b0, 3'd0};
    vecs[5] = '{3'd3, 8'd3,   1'b0, 1'b1, 3'd3};
    vecs[6] = '{3'd4, 8'd128, 1'b0, 1'b1, 3'd4};
    vecs[7] = '{3'd2, 8'd200, 1'b1, 1'b0, 3'd0};

    clock_areset_n = 1'b0;
    start = 1'b0; xres_select = 3'd0; yres = 8'd0;
    kin_valid = 1'b1; kin_data = 16'hBEEF;
    pin_valid = 1'b1; pin_data = 16'hCAFE;
    mon_clr = 1'b1;
    #1;
    check_all_zero("reset_outputs");
    @(negedge clock);
    @(negedge clock);
    kin_valid = 1'b0; pin_valid = 1'b0;
    clock_areset_n = 1'b1;
    @(negedge clock);

    // Start validation table
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; xres_select = vecs[i].sel; yres = vecs[i].yr;
      @(negedge clock);
      start = 1'b0;
      #1;
      check("vec_err", err, vecs[i].exp_err);
      check("vec_busy", busy, vecs[i].exp_busy);
      check("vec_kin_ready", kin_ready, vecs[i].exp_busy);
      check("vec_cfg", cfg_xres_select, vecs[i].exp_cfg);
      @(negedge clock);
      #1;
      check("vec_err_one_cycle", err, 0);
      check("vec_busy_held", busy, vecs[i].exp_busy);
      if (vecs[i].exp_busy) begin
        clock_areset_n = 1'b0;
        #1;
        check_all_zero("vec_reset_outputs");
        @(negedge clock);
        clock_areset_n = 1'b1;
      end
      @(negedge clock);
    end

    // Nominal frame
    clear_mon();
    run_frame(1'b0, -1, 1'b0);
    frame_checks("nominal", 1);
    check("nominal_cfg", cfg_xres_select, 3);

    // Backpressure on both streams
    @(negedge clock);
    clear_mon();
    run_frame(1'b1, -1, 1'b0);
    frame_checks("backpressure", 1);

    // Start while busy with a different configuration
    @(negedge clock);
    clear_mon();
    run_frame(1'b0, -1, 1'b1);
    frame_checks("start_busy", 1);
    check("start_busy_cfg_held", cfg_xres_select, 3);

    // Reset after pixel 7, then a clean nominal frame
    @(negedge clock);
    clear_mon();
    run_frame(1'b0, 8, 1'b0);
    @(negedge clock);
    #1;
    check_all_zero("outputs_held_in_reset");
    @(negedge clock);
    clock_areset_n = 1'b1;
    clear_mon();
    run_frame(1'b0, -1, 1'b0);
    frame_checks("after_reset", 1);

    // Back-to-back frames, second start in the busy-fall cycle
    @(negedge clock);
    clear_mon();
    run_frame(1'b0, -1, 1'b0);
    run_frame(1'b0, -1, 1'b0);
    frame_checks("back_to_back", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequencer for one K×K convolution engine with line buffers and a sum-of-products tree. It configures the engine's x resolution, streams K*K kernel coefficients into the kernel shift chain, and then streams one frame of pixels into the line buffers. It asserts the engine's compute enable only when the window holds K complete rows and columns. It counts returned results and reports frame completion.

## Interface
- MAX_XRES, 128, longest supported line length
- MAX_YRES, 128, largest supported frame height
- XRES1..XRES5, 16/32/64/4/8, line lengths selected by xres_select 0..4
- K, 3, kernel edge
- WIDTH, 16, coefficient/pixel word width
- clock  in  1  system clock; all state on rising edge
- clock_areset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame request; sampled only in IDLE
- xres_select  in  3  line-length select; latched on accepted start
- yres  in  $clog2(MAX_YRES+1)  frame rows; latched on accepted start
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse when frame complete
- err  out  1  one-cycle pulse when start is rejected
- kin_valid / kin_ready / kin_data  in/out/in  1/1/WIDTH  kernel coefficient stream
- pin_valid / pin_ready / pin_data  in/out/in  1/1/WIDTH  pixel stream, raster order
- cfg_xres_select  out  3  latched select to engine
- kernel_data_shift / kernel_data  out  1/WIDTH  engine kernel chain
- data_shift / data  out  1/WIDTH  engine line-buffer input
- enable_calc  out  1  engine compute enable
- result_valid  in  1  engine result strobe; counted only

## Operation
- States: IDLE, LOAD_KERNEL, STREAM, DRAIN, DONE.
- IDLE + start:
  - Reject with an err pulse and stay in IDLE if any of these hold: xres_select>4, yres<K, yres>MAX_YRES.
  - Otherwise latch the configuration, clear all counters, and go to LOAD_KERNEL.
- LOAD_KERNEL:
  - kin_ready=1.
  - kernel_data_shift = kin_valid&kin_ready; kernel_data = kin_data (combinational pass-through).
  - After the K*K-th handshake, go to STREAM.
- STREAM:
  - pin_ready=1.
  - data_shift = pin_valid&pin_ready; data = pin_data (combinational).
  - Counters x (0..xres-1) and y (0..yres-1) advance per handshake; x wraps to 0 and y increments.
  - A handshake with x≥K-1 and y≥K-1 schedules enable_calc in the next cycle.
  - After handshake xres*yres, go to DRAIN.
- DRAIN: wait until result_count == expected = (xres-K+1)*(yres-K+1), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- result_count increments on every result_valid while busy. The compare includes the current-cycle strobe, so the final strobe in STREAM or DRAIN reaches DONE on the next edge.
- Result strobes beyond expected are ignored, with the count saturating at expected. result_valid in IDLE is ignored.
- start while busy is ignored; no err.
- cfg_xres_select holds its value from start until the next accepted start.
- Widths:
  - x counter: $clog2(MAX_XRES).
  - y counter: $clog2(MAX_YRES+1).
  - result_count and expected: $clog2(MAX_XRES*MAX_YRES+1).
  - Products are computed at start from the latched values.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - busy, done, err, enable_calc, kin_ready, pin_ready, kernel_data_shift, data_shift: 0.
  - cfg_xres_select 0.
  - Outputs return to these values immediately on reset, including mid-frame; no partial-frame recovery.
- Accepted start at edge N: busy=1 and kin_ready=1 from cycle N+1.
- The final kernel handshake at edge M puts pin_ready=1 from cycle M+1; no bubble other than the state change.
- enable_calc is registered. It is high in the cycle immediately after a qualifying data_shift edge, when the engine window already holds that pixel. It is one cycle wide per qualifying pixel, and back-to-back pixels give back-to-back pulses.
- Stalls (valid low) freeze all counters; enable_calc is never asserted during a stall cycle without a preceding qualifying handshake.
- The last pixel's enable_calc pulse occurs in the first DRAIN cycle.
- busy falls in the cycle after DONE; a new start is accepted in that same cycle.

## Test plan
- Nominal frame: xres_select=3 (4-wide), yres=4, K=3, 9 kernel words, then 16 pixels with no gaps.
  - kernel_data_shift fires exactly 9 times.
  - enable_calc fires exactly 4 times, one cycle after pixel indices 10, 11, 14, 15.
  - With a 5-cycle-latency result stub, done pulses once after the 4th result_valid.
- Backpressure: same frame with random valid gaps on both streams.
  - enable_calc count and relative pixel indices are unchanged.
  - No shift occurs while valid is low.
- Rejection: start with xres_select=5, then with yres=2.
  - Each gives an err pulse; busy stays 0 and the state stays IDLE.
- Start while busy: pulse start mid-STREAM with different configuration.
  - cfg_xres_select is unchanged; no err; the frame completes normally.
- Reset mid-frame: assert clock_areset_n=0 after pixel 7.
  - All outputs are 0 asynchronously.
  - A subsequent nominal frame reproduces the first test's exact results.
- Back-to-back frames: start in the cycle busy falls.
  - The second frame is accepted; result_count restarts at 0; two done pulses total.
